// File: rtl/aes_dec_pkg.sv
// Shared types, constants and pure GF(2^8)/state-transform helpers for the AES-128 decrypt core.
package aes_dec_pkg;

  localparam int unsigned NR    = 10;
  localparam int unsigned BLK_W = 128;

  localparam logic [3:0] LastRound = 4'(NR - 1);

  typedef enum logic [1:0] {StIdle, StKexp, StDec, StDone} dec_state_e;

  localparam logic [7:0] RCON [NR] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                       8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon_next(input logic [7:0] rc);
    return xtime(rc);
  endfunction

  // Inverse of xtime: undo the conditional 0x1b reduction before shifting back.
  function automatic logic [7:0] rcon_prev(input logic [7:0] rc);
    return rc[0] ? {1'b1, rc[7:1] ^ 7'h0d} : {1'b0, rc[7:1]};
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Byte i of the block sits at bits [127-8i -: 8]; row = i % 4, column = i / 4.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) begin
      for (int w = 0; w < 4; w++) begin
        r[127 - 8 * (w + 4 * c) -: 8] = s[127 - 8 * (w + 4 * ((c - w) & 3)) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32 * c -: 8];
      a1 = s[119 - 32 * c -: 8];
      a2 = s[111 - 32 * c -: 8];
      a3 = s[103 - 32 * c -: 8];
      r[127 - 32 * c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^
                             gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      r[119 - 32 * c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^
                             gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      r[111 - 32 * c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^
                             gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      r[103 - 32 * c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^
                             gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_sbox_pair.sv
// Byte-wide AES S-box; Inverse selects the inverse S-box, otherwise the forward one.
module aes_sbox_pair
  import aes_dec_pkg::*;
#(
  parameter bit Inverse = 1'b0
) (
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] p;
    sq = x;
    p  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      p  = gf_mul(p, sq);
    end
    return p;
  endfunction

  if (Inverse) begin : g_inv
    logic [7:0] pre;
    assign pre    = rotl8(data_i, 1) ^ rotl8(data_i, 3) ^ rotl8(data_i, 6) ^ 8'h05;
    assign data_o = gf_inv(pre);
  end else begin : g_fwd
    logic [7:0] inv;
    assign inv    = gf_inv(data_i);
    assign data_o = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  end

endmodule

// File: rtl/aes_128_decrypt.sv
// Iterative AES-128 decryption: forward key expansion, then ten inverse rounds one per cycle.
// Define AES_DEC_KEY_CACHE_EN to skip key expansion when the key matches the last expanded one.
module aes_128_decrypt
  import aes_dec_pkg::*;
#(
  parameter bit ZERO_OUT_IDLE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] state,
  input  logic [BLK_W-1:0] key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out
);

  dec_state_e       st_q, st_d;
  logic [BLK_W-1:0] s_q, s_d, kr_q, kr_d;
  logic [7:0]       rc_q, rc_d;
  logic [3:0]       cnt_q, cnt_d;

  // Key schedule: one set of four forward S-boxes serves both directions.
  logic [31:0] wa, wb, wc, wd, inv_wd, sub_in, sub_out, new_wa;
  logic [BLK_W-1:0] kr_fwd, kr_inv;

  assign wa     = kr_q[127:96];
  assign wb     = kr_q[95:64];
  assign wc     = kr_q[63:32];
  assign wd     = kr_q[31:0];
  assign inv_wd = wd ^ wc;
  assign sub_in = rot_word((st_q == StDec) ? inv_wd : wd);

  for (genvar i = 0; i < 4; i++) begin : g_key_sbox
    aes_sbox_pair #(.Inverse(1'b0)) u_sbox (
      .data_i(sub_in[8*i +: 8]),
      .data_o(sub_out[8*i +: 8])
    );
  end

  assign new_wa = wa ^ sub_out ^ {rc_q, 24'h000000};
  assign kr_fwd = {new_wa, wb ^ new_wa, wc ^ wb ^ new_wa, wd ^ wc ^ wb ^ new_wa};
  assign kr_inv = {new_wa, wb ^ wa, wc ^ wb, inv_wd};

  logic [BLK_W-1:0] isr, isb, t;
  assign isr = inv_shift_rows(s_q);

  for (genvar i = 0; i < 16; i++) begin : g_state_sbox
    aes_sbox_pair #(.Inverse(1'b1)) u_sbox (
      .data_i(isr[8*i +: 8]),
      .data_o(isb[8*i +: 8])
    );
  end

  assign t = isb ^ kr_inv;

  logic             cache_hit;
  logic [BLK_W-1:0] cache_k10;

`ifdef AES_DEC_KEY_CACHE_EN
  logic [BLK_W-1:0] cache_key_q, cache_k10_q;
  logic             cache_vld_q;

  assign cache_hit = cache_vld_q && (key == cache_key_q);
  assign cache_k10 = cache_k10_q;

  // The key is captured at acceptance; the entry only becomes valid once its k10 is complete.
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_vld_q <= 1'b0;
    end else if (st_q == StIdle && in_valid && !cache_hit) begin
      cache_key_q <= key;
      cache_vld_q <= 1'b0;
    end else if (st_q == StKexp && cnt_q == LastRound) begin
      cache_k10_q <= kr_fwd;
      cache_vld_q <= 1'b1;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign cache_k10 = '0;
`endif

  always_comb begin
    st_d  = st_q;
    s_d   = s_q;
    kr_d  = kr_q;
    rc_d  = rc_q;
    cnt_d = cnt_q;
    unique case (st_q)
      StIdle: begin
        if (in_valid) begin
          if (cache_hit) begin
            kr_d  = cache_k10;
            s_d   = state ^ cache_k10;
            rc_d  = RCON[NR-1];
            cnt_d = LastRound;
            st_d  = StDec;
          end else begin
            kr_d  = key;
            s_d   = state;
            rc_d  = RCON[0];
            cnt_d = 4'd0;
            st_d  = StKexp;
          end
        end
      end
      StKexp: begin
        kr_d  = kr_fwd;
        rc_d  = rcon_next(rc_q);
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LastRound) begin
          s_d   = s_q ^ kr_fwd;
          rc_d  = RCON[NR-1];
          cnt_d = LastRound;
          st_d  = StDec;
        end
      end
      StDec: begin
        kr_d  = kr_inv;
        rc_d  = rcon_prev(rc_q);
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd0) begin
          s_d  = t;
          st_d = StDone;
        end else begin
          s_d = inv_mix_columns(t);
        end
      end
      StDone: begin
        if (out_ready) st_d = StIdle;
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= StIdle;
      s_q   <= '0;
      kr_q  <= '0;
      rc_q  <= 8'h00;
      cnt_q <= 4'd0;
    end else begin
      st_q  <= st_d;
      s_q   <= s_d;
      kr_q  <= kr_d;
      rc_q  <= rc_d;
      cnt_q <= cnt_d;
    end
  end

  assign in_ready  = (st_q == StIdle);
  assign out_valid = (st_q == StDone);
  assign out       = (ZERO_OUT_IDLE && !out_valid) ? '0 : s_q;

endmodule

// File: tb/tb_aes_128_decrypt.sv
// Directed bench for aes_128_decrypt using FIPS-197 vectors; honours AES_DEC_KEY_CACHE_EN.
module tb_aes_128_decrypt;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] ct = '0;
  logic [127:0] kin = '0;
  logic         in_ready, out_valid;
  logic [127:0] pt;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] K1    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C1    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P1    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K10_1 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K2    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C2    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P2    = 128'h00112233445566778899aabbccddeeff;

`ifdef AES_DEC_KEY_CACHE_EN
  localparam int CachedLat = 10;
`else
  localparam int CachedLat = 20;
`endif

  aes_128_decrypt #(.ZERO_OUT_IDLE(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .state    (ct),
    .key      (kin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (pt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
      $error("check %s did not match", tag);
    end
  endtask

  // Offers one block, waits for the result, optionally holds backpressure, then drains it.
  task automatic run_block(input string tag, input logic [127:0] kk, input logic [127:0] c,
                           input logic [127:0] p, input int exp_lat, input int pulse_at,
                           input int hold, input bit chk_k10);
    int lat;
    lat = 0;
    while (!in_ready && lat < 50) begin
      step();
      lat++;
    end
    check({tag, "_in_ready"}, 128'(in_ready), 128'd1);
    kin      = kk;
    ct       = c;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat      = 0;
    while (!out_valid && lat < 100) begin
      if (chk_k10 && lat == 10) check({tag, "_k10"}, dut.kr_q, K10_1);
      if (lat == pulse_at) begin
        in_valid = 1'b1;
        kin      = {$urandom, $urandom, $urandom, $urandom};
        ct       = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        in_valid = 1'b0;
      end
      step();
      lat++;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    check({tag, "_out"}, pt, p);
    if (chk_k10) check({tag, "_key_back"}, dut.kr_q, kk);
    for (int i = 0; i < hold; i++) begin
      step();
      check({tag, "_hold_out"}, pt, p);
      check({tag, "_hold_valid"}, 128'(out_valid), 128'd1);
      check({tag, "_hold_in_ready"}, 128'(in_ready), 128'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_drain_valid"}, 128'(out_valid), 128'd0);
    check({tag, "_drain_in_ready"}, 128'(in_ready), 128'd1);
    check({tag, "_drain_out_zero"}, pt, 128'd0);
  endtask

  initial begin
    bit seen;
    repeat (2) step();
    rst = 1'b0;
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out", pt, 128'd0);
    check("rst_s", dut.s_q, 128'd0);
    check("rst_kr", dut.kr_q, 128'd0);

    // FIPS-197 App. B with k10 and recovered-key checks.
    run_block("vec1", K1, C1, P1, 20, -1, 0, 1'b1);
    // Same key again, garbage offered mid-decrypt must be ignored.
    run_block("vec1_busy", K1, C1, P1, CachedLat, CachedLat - 3, 0, 1'b0);
    // FIPS-197 App. C.1 under 15 cycles of backpressure.
    run_block("vec2_bp", K2, C2, P2, 20, -1, 15, 1'b0);

    // Abort a block partway through key expansion.
    kin      = K1;
    ct       = C1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (6) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_in_ready", 128'(in_ready), 128'd1);
    check("abort_out_valid", 128'(out_valid), 128'd0);
    check("abort_out", pt, 128'd0);
    seen = 1'b0;
    repeat (25) begin
      if (out_valid) seen = 1'b1;
      step();
    end
    check("abort_no_output", 128'(seen), 128'd0);

    run_block("vec2_after_rst", K2, C2, P2, 20, -1, 0, 1'b0);
    run_block("vec2_repeat", K2, C2, P2, CachedLat, -1, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
